bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Parametrised successor to the minutes/seconds packing register: owns the BCD time digits instead of only packing them.
- NUM_DIGITS-digit BCD up/down time counter with load, start/stop control, a 1 Hz tick enable, and expiry detection.
- Registered packed BCD output feeds the display/seven-segment path unchanged.
- Sits between the button/debounce logic and the display driver in the kitchen timer.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; must be even and >= 2; digit 0 is the least significant.
- MMSS, 1, 1 = digit 1 (seconds tens) and every odd digit below NUM_DIGITS-1 limited to 0-5 (sexagesimal pairs); 0 = all digits 0-9.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  load load_value into the counter.
- load_value  input  4*NUM_DIGITS  packed BCD preset; digit i at bits [4i+3:4i].
- dir  input  1  0 = count down, 1 = count up; sampled on each tick.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- tick  input  1  one-cycle count enable (1 Hz strobe).
- big_bin  output  4*NUM_DIGITS  registered packed BCD of the current count.
- running  output  1  high in RUN.
- zero  output  1  registered; high when all digits are 0.
- done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (async, any time, including mid-count): digits = 0, state IDLE; big_bin = 0, running = 0, zero = 1, done = 0.
- States:
  - IDLE: no count loaded or counting stopped after load.
  - RUN: counting.
  - PAUSED: stopped mid-count.
  - EXPIRED: count reached its limit.
- Priority, per cycle: load > stop > start > tick.
- load (any state):
  - Digits take load_value.
  - Any digit above its limit (9, or 5 for limited digits) is clamped to the limit.
  - Next state is IDLE; tick is ignored that cycle.
- stop: RUN -> PAUSED. In other states stop has no effect.
- start, from IDLE, PAUSED or EXPIRED:
  - Goes to RUN, unless dir = 0 with count 0, or dir = 1 with count at max. Then start is ignored and the state is unchanged.
  - The tick in the same cycle is not counted.
- tick counts only in RUN; ticks in other states are ignored.
- Down count:
  - Digit 0 decrements.
  - A digit at 0 wraps to its limit and borrows from the next digit.
- Up count:
  - Digit 0 increments.
  - A digit at its limit wraps to 0 and carries into the next digit.
- Expiry:
  - Down: the tick that produces all-zero digits.
  - Up: the tick that produces all digits at their limits (max, e.g. 99:59).
  - On that tick, state -> EXPIRED. done pulses on the next cycle, aligned with big_bin.
  - The counter never wraps past 0 or past max.
- dir change while in RUN takes effect on the next tick, with no extra cycle.
- Latency:
  - Digit register updates on the edge where the tick is sampled.
  - big_bin, zero and done update one clock later.
  - Total: 1 cycle from digit update to outputs.
- running is combinational from the state register (same cycle as the state).

Optional Feature:
- Macro: BCD_TIME_COUNTER_DISPLAY_HOLD_EN.
- When defined:
  - Adds input hold (1 bit).
  - While hold = 1, big_bin is frozen at its value when hold rose; internal counting, zero and done continue normally.
  - After hold falls, big_bin shows the current count on the next clock.
- When undefined: no hold port; big_bin always tracks the count with 1-cycle latency.

Test Plan:
- Reset mid-RUN at count 0x0130 -> big_bin = 0x0000, zero = 1, running = 0 immediately (asynchronous).
- load 0x0100, start, 1 tick -> big_bin = 0x0059 one cycle after the tick.
- Continue 59 more ticks -> big_bin = 0x0000, done high for exactly 1 cycle, state EXPIRED; further ticks leave 0x0000.
- load 0x0A7C (MMSS = 1) -> clamped to 0x0959; start with dir = 1, tick to 0x9959 -> done pulse, saturated.
- start + tick in the same cycle from IDLE at 0x0005 -> no decrement that cycle. stop + tick in RUN -> PAUSED, count held. start at 0x0000 with dir = 0 -> stays IDLE.
- (With macro) hold = 1 at 0x0045, 3 ticks -> big_bin stays 0x0045; release hold -> big_bin = 0x0042 next cycle.

Source files
------------

// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - control/status bundle for bcd_time_counter (hold port under BCD_TIME_COUNTER_DISPLAY_HOLD_EN)
interface bcd_time_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic                      dir;
  logic                      start;
  logic                      stop;
  logic                      tick;
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
  logic                      hold;
`endif
  logic [4*NUM_DIGITS-1:0]   big_bin;
  logic                      running;
  logic                      zero;
  logic                      done;

  modport master (
    output load, load_value, dir, start, stop, tick,
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
    output hold,
`endif
    input  big_bin, running, zero, done
  );

  modport slave (
    input  load, load_value, dir, start, stop, tick,
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
    input  hold,
`endif
    output big_bin, running, zero, done
  );
endinterface

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - BCD up/down time counter with load, start/stop and expiry (optional display hold: BCD_TIME_COUNTER_DISPLAY_HOLD_EN)
module bcd_time_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int MMSS       = 1
) (
  input logic             clock,
  input logic             reset,
  bcd_time_counter_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, EXPIRED = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic [W-1:0]   clamp_val, inc_val, dec_val;
  logic [W-1:0]   big_bin_q;
  logic           is_zero, is_max, inc_max, dec_zero;
  logic           expire_q, expire_d;
  logic           zero_q, done_q;

  // Seconds-tens style digits (odd positions below the top digit) only reach 5.
  function automatic logic [3:0] limit_of(input int i);
    if (MMSS != 0 && (i % 2) == 1 && i < NUM_DIGITS - 1) return 4'd5;
    return 4'd9;
  endfunction

  // Per-digit clamp of the preset, ripple increment/decrement and end-of-range flags
  always_comb begin
    logic       carry, borrow;
    logic [3:0] d, lim, lv;
    clamp_val = '0;
    inc_val   = '0;
    dec_val   = '0;
    is_zero   = 1'b1;
    is_max    = 1'b1;
    inc_max   = 1'b1;
    dec_zero  = 1'b1;
    carry     = 1'b1;
    borrow    = 1'b1;
    d         = '0;
    lim       = '0;
    lv        = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d   = digits_q[4*i +: 4];
      lim = limit_of(i);
      lv  = bus.load_value[4*i +: 4];
      clamp_val[4*i +: 4] = (lv > lim) ? lim : lv;
      if (d != 4'd0) is_zero = 1'b0;
      if (d != lim)  is_max  = 1'b0;
      if (!carry) begin
        inc_val[4*i +: 4] = d;
      end else if (d >= lim) begin
        inc_val[4*i +: 4] = 4'd0;
      end else begin
        inc_val[4*i +: 4] = d + 4'd1;
        carry = 1'b0;
      end
      if (!borrow) begin
        dec_val[4*i +: 4] = d;
      end else if (d == 4'd0) begin
        dec_val[4*i +: 4] = lim;
      end else begin
        dec_val[4*i +: 4] = d - 4'd1;
        borrow = 1'b0;
      end
      if (inc_val[4*i +: 4] != lim)  inc_max  = 1'b0;
      if (dec_val[4*i +: 4] != 4'd0) dec_zero = 1'b0;
    end
  end

  // Next state and digits: load > stop > start > tick; a tick at the range end saturates and expires
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    expire_d = 1'b0;
    if (bus.load) begin
      digits_d = clamp_val;
      state_d  = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) state_d = PAUSED;
    end else if (bus.start) begin
      if (state_q != RUN && !(!bus.dir && is_zero) && !(bus.dir && is_max)) state_d = RUN;
    end else if (bus.tick && state_q == RUN) begin
      if (bus.dir) begin
        if (is_max) begin
          state_d  = EXPIRED;
          expire_d = 1'b1;
        end else begin
          digits_d = inc_val;
          if (inc_max) begin
            state_d  = EXPIRED;
            expire_d = 1'b1;
          end
        end
      end else begin
        if (is_zero) begin
          state_d  = EXPIRED;
          expire_d = 1'b1;
        end else begin
          digits_d = dec_val;
          if (dec_zero) begin
            state_d  = EXPIRED;
            expire_d = 1'b1;
          end
        end
      end
    end
  end

  // State, digit and expiry-event registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      digits_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      expire_q <= expire_d;
    end
  end

  // Output stage one clock behind the digits, so done lines up with the final big_bin
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      big_bin_q <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
      if (!bus.hold) big_bin_q <= digits_q;
`else
      big_bin_q <= digits_q;
`endif
      zero_q <= is_zero;
      done_q <= expire_q;
    end
  end

  assign bus.big_bin = big_bin_q;
  assign bus.zero    = zero_q;
  assign bus.done    = done_q;
  assign bus.running = (state_q == RUN);

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - scoreboard bench for bcd_time_counter against a mixed-radix value model
module tb_bcd_time_counter;
  localparam int N    = 4;
  localparam int MMSS = 1;
  localparam int W    = 4 * N;
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] bb;
    logic         zero;
    logic         done;
    logic         running;
  } exp_t;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bcd_time_counter_if #(.NUM_DIGITS(N)) bus();

  bcd_time_counter #(.NUM_DIGITS(N), .MMSS(MMSS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  int           m_val;
  int           m_st;
  bit           m_exp;
  logic [W-1:0] m_bb;
  int           max_val;

  function automatic int radix(input int i);
    return (MMSS != 0 && (i % 2) == 1 && i < N - 1) ? 6 : 10;
  endfunction

  function automatic logic [W-1:0] clamp(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      r[4*i +: 4] = (int'(b[4*i +: 4]) > radix(i) - 1) ? 4'(radix(i) - 1) : b[4*i +: 4];
    return r;
  endfunction

  function automatic int to_val(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * radix(i) + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] from_val(input int v);
    logic [W-1:0] b;
    int x;
    b = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      b[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic model_reset();
    m_val = 0;
    m_st  = S_IDLE;
    m_exp = 1'b0;
    m_bb  = '0;
  endtask

  // One clock of the reference: outputs reflect the pre-edge value, then the value moves.
  task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic dr,
                            input logic st, input logic sp, input logic tk, input logic hd);
    exp_t e;
    e.bb   = (HOLD_EN && hd) ? m_bb : from_val(m_val);
    m_bb   = e.bb;
    e.zero = (m_val == 0);
    e.done = m_exp;
    m_exp  = 1'b0;
    if (ld) begin
      m_val = to_val(clamp(lv));
      m_st  = S_IDLE;
    end else if (sp) begin
      if (m_st == S_RUN) m_st = S_PAUSED;
    end else if (st) begin
      if (m_st != S_RUN && !(!dr && m_val == 0) && !(dr && m_val == max_val)) m_st = S_RUN;
    end else if (tk && m_st == S_RUN) begin
      if (dr) begin
        if (m_val < max_val) m_val++;
        if (m_val == max_val) begin m_st = S_EXP; m_exp = 1'b1; end
      end else begin
        if (m_val > 0) m_val--;
        if (m_val == 0) begin m_st = S_EXP; m_exp = 1'b1; end
      end
    end
    e.running = (m_st == S_RUN);
    sb.push_back(e);
  endtask

  // Called at a falling edge: drive, predict, then advance to the next falling edge.
  task automatic cyc(input logic ld, input logic [W-1:0] lv, input logic dr,
                     input logic st, input logic sp, input logic tk, input logic hd);
    bus.load       = ld;
    bus.load_value = lv;
    bus.dir        = dr;
    bus.start      = st;
    bus.stop       = sp;
    bus.tick       = tk;
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
    bus.hold       = hd;
`endif
    model_step(ld, lv, dr, st, sp, tk, hd);
    @(negedge clock);
  endtask

  // Monitor: every clock the DUT presents a new output word; compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_total++;
        if (bus.big_bin === e.bb && bus.zero === e.zero && bus.done === e.done && bus.running === e.running)
          n_pass++;
        else
          $display("FAIL scoreboard @%0t: got big_bin=%h zero=%b done=%b running=%b, expected big_bin=%h zero=%b done=%b running=%b",
                   $time, bus.big_bin, bus.zero, bus.done, bus.running, e.bb, e.zero, e.done, e.running);
      end
    end
  end

  initial begin
    logic         dr, hd;
    logic [W-1:0] lv;
    max_val = 1;
    for (int i = 0; i < N; i++) max_val = max_val * radix(i);
    max_val = max_val - 1;

    bus.load = 0; bus.load_value = '0; bus.dir = 0; bus.start = 0; bus.stop = 0; bus.tick = 0;
`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
    bus.hold = 0;
`endif
    model_reset();
    #23;
    chk("reset_big_bin", 32'(bus.big_bin), 32'h0);
    chk("reset_zero", 32'(bus.zero), 32'h1);
    chk("reset_running", 32'(bus.running), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset while running at 01:30
    cyc(1, 16'h0130, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_big_bin", 32'(bus.big_bin), 32'h0);
    chk("midrun_reset_zero", 32'(bus.zero), 32'h1);
    chk("midrun_reset_running", 32'(bus.running), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // 01:00 count down to expiry
    cyc(1, 16'h0100, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("first_tick_big_bin", 32'(bus.big_bin), 32'h0059);
    for (int k = 0; k < 59; k++) cyc(0, '0, 0, 0, 0, 1, 0);
    chk("expired_running", 32'(bus.running), 32'h0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("expiry_big_bin", 32'(bus.big_bin), 32'h0);
    chk("expiry_done", 32'(bus.done), 32'h1);
    cyc(0, '0, 0, 0, 0, 1, 0);
    chk("done_one_cycle", 32'(bus.done), 32'h0);
    cyc(0, '0, 0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("expired_holds_zero", 32'(bus.big_bin), 32'h0);

    // Clamped preset, count up to 99:59
    cyc(1, 16'h0A7C, 1, 0, 0, 0, 0);
    cyc(0, '0, 1, 0, 0, 0, 0);
    chk("clamp_big_bin", 32'(bus.big_bin), 32'h0959);
    cyc(0, '0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5400; k++) cyc(0, '0, 1, 0, 0, 1, 0);
    cyc(0, '0, 1, 0, 0, 1, 0);
    chk("up_max_big_bin", 32'(bus.big_bin), 32'h9959);
    chk("up_done", 32'(bus.done), 32'h1);
    cyc(0, '0, 1, 1, 0, 0, 0);
    chk("start_at_max_ignored", 32'(bus.running), 32'h0);

    // Same-cycle start+tick, stop+tick, start at zero
    cyc(1, 16'h0005, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("start_tick_no_count", 32'(bus.big_bin), 32'h0005);
    chk("start_tick_running", 32'(bus.running), 32'h1);
    cyc(0, '0, 0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 1, 1, 0);
    cyc(0, '0, 0, 0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("stop_tick_held", 32'(bus.big_bin), 32'h0004);
    chk("paused_running", 32'(bus.running), 32'h0);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0, 0);
    chk("start_at_zero_ignored", 32'(bus.running), 32'h0);

`ifdef BCD_TIME_COUNTER_DISPLAY_HOLD_EN
    // Display freeze while counting continues underneath
    cyc(1, 16'h0045, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, '0, 0, 0, 0, 1, 1);
    cyc(0, '0, 0, 0, 0, 0, 1);
    chk("hold_frozen", 32'(bus.big_bin), 32'h0045);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("hold_release", 32'(bus.big_bin), 32'h0042);
`endif

    // Randomized traffic, with presets biased toward both range ends
    dr = 1'b0;
    hd = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      if (HOLD_EN && $urandom_range(0, 9) == 0) hd = ~hd;
      case ($urandom_range(0, 2))
        0:       lv = 16'($urandom);
        1:       lv = 16'h0003;
        default: lv = 16'h9956;
      endcase
      cyc(($urandom_range(0, 39) == 0), lv, dr, ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), hd);
    end
    cyc(0, '0, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
